// File: rtl/sram_access_controller.sv
// Sequences 32-bit MEM-stage loads/stores as two halfword phases on a 16-bit async SRAM.
// Latency: 2*(WAIT_CYCLES+1)+1 stalled cycles per access; ready low stalls the whole pipeline.
// Optional SRAM_POSTED_WRITE_EN: writes are acknowledged at once and drain in the background.
module sram_access_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int          WW        = SRAM_AW - 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         wcnt_q, wcnt_d;
    logic               op_wr_q, op_wr_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               be_n_q, be_n_d;

    logic [WW-1:0]      req_word;
    logic               phase_last;
    logic               active_d;
    logic               hi_d;

    assign req_word   = WW'((address - 32'(BASE_ADDR)) >> 2);
    assign phase_last = (wcnt_q == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;

        case (state_q)
            IDLE: begin
                wcnt_d = 4'd0;
                if (wr_en | rd_en) begin
                    state_d = LO;
                    op_wr_d = wr_en;
                    word_d  = req_word;
                    wdata_d = write_data;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_d = HI;
                    wcnt_d  = 4'd0;
                    if (!op_wr_q) read_data_d[15:0] = sram_dq_in;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            HI: begin
                if (phase_last) begin
`ifdef SRAM_POSTED_WRITE_EN
                    // A posted write was already acknowledged; skip DONE so a waiting request starts sooner.
                    state_d = op_wr_q ? IDLE : DONE;
`else
                    state_d = DONE;
`endif
                    wcnt_d  = 4'd0;
                    if (!op_wr_q) read_data_d[31:16] = sram_dq_in;
                end else begin
                    wcnt_d = wcnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pins are registered from the next state so they line up exactly with the LO/HI cycles.
    always_comb begin
        active_d    = (state_d == LO) || (state_d == HI);
        hi_d        = (state_d == HI);
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        if (active_d) begin
            sram_addr_d = {word_d, hi_d};
            if (op_wr_d) dq_out_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
        end
        dq_oe_d = active_d & op_wr_d;
        ce_n_d  = ~active_d;
        be_n_d  = ~active_d;
        oe_n_d  = ~(active_d & ~op_wr_d);
        we_n_d  = ~(active_d & op_wr_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            read_data_q <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            be_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            be_n_q      <= be_n_d;
        end
    end

    assign ready = ~(rd_en | wr_en) | (state_q == DONE)
`ifdef SRAM_POSTED_WRITE_EN
                 | ((state_q == IDLE) & wr_en)
`endif
                 ;

    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = be_n_q;
    assign sram_lb_n   = be_n_q;

endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Sequences every data-memory access issued by the MEM stage onto a 16-bit asynchronous external SRAM.
- Each 32-bit word is split into two halfword phases with programmable wait states.
- Drives the pipeline-wide ready signal: while it is low, IF/ID/EXE/MEM all freeze.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 1: extra cycles each halfword phase is held (0..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request from MEM stage; held until ready is seen high.
- rd_en  input  1  read request from MEM stage; held until ready is seen high.
- address  input  32  CPU byte address.
- write_data  input  32  store data.
- read_data  output  32  load data, registered.
- ready  output  1  access complete / no access pending; low stalls the pipeline.
- sram_addr  output  SRAM_AW  SRAM halfword address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_oe  output  1  1 = controller drives the DQ bus.
- sram_dq_in  input  16  SRAM read data.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Address mapping: word = (address - BASE_ADDR) >> 2, modulo 2^32, truncated to SRAM_AW-1 bits. Low phase uses sram_addr = {word,0}; high phase uses {word,1}.
- FSM states: IDLE, LO, HI, DONE. A 4-bit wait counter wcnt counts within LO and HI.
  - IDLE: if wr_en|rd_en, capture op (write wins when both are set), address and write_data; go to LO with wcnt=0.
  - LO: after WAIT_CYCLES+1 cycles (wcnt==WAIT_CYCLES), go to HI with wcnt=0. On a read, latch read_data[15:0] <= sram_dq_in in that final cycle.
  - HI: same timing; on a read, latch read_data[31:16]. Then go to DONE.
  - DONE: one cycle, then IDLE.
- ready = ~(rd_en|wr_en) | (state==DONE), combinational. With WAIT_CYCLES=1, a request raised in cycle 0 sees ready low for cycles 0-4 and high in cycle 5. General latency is 2*(WAIT_CYCLES+1)+1 stalled cycles.
- SRAM pins in LO/HI:
  - sram_ce_n=0, sram_ub_n=0, sram_lb_n=0 throughout.
  - Read: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - Write: sram_we_n=0, sram_oe_n=1, sram_dq_oe=1, sram_dq_out = write_data[15:0] in LO and [31:16] in HI, stable for the whole phase.
- SRAM pins in IDLE/DONE: all strobes 1, sram_dq_oe=0, sram_addr holds its last value.
- read_data changes only on read completion; it holds across writes and idle cycles.
- Request dropped mid-access (not legal): the access still completes to DONE.
- Reset, including mid-access: state=IDLE, wcnt=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all _n strobes=1. ready follows its equation.

Optional Feature:
- Macro: SRAM_POSTED_WRITE_EN.
- Defined:
  - A write in IDLE is acknowledged immediately: ready=1 in the request cycle, with address/data captured into a one-entry post buffer, and the SRAM write then runs LO/HI in the background.
  - A new request arriving while the post drains sees ready=0 until the post completes; the new request then proceeds normally.
  - A read to the same word as the pending post also waits; no forwarding.
- Undefined: every write stalls exactly like a read.

Test Plan:
- Reset, WAIT_CYCLES=1: rst=1 for 2 cycles -> all strobes 1, read_data=0, ready=1, sram_dq_oe=0.
- Write then read: wr_en, address=1028, write_data=0xDEADBEEF -> sram_addr 2 then 3, sram_dq_out 0xBEEF then 0xDEAD, ready low 5 cycles. A subsequent rd_en at 1028, with the SRAM model returning stored data, gives read_data=0xDEADBEEF with ready high on cycle 6.
- WAIT_CYCLES=0: a read stalls exactly 3 cycles; WAIT_CYCLES=3 stalls 9 cycles.
- Simultaneous rd_en=wr_en=1 at 1024 -> write performed (sram_we_n=0), read_data unchanged.
- rst asserted during the HI phase of a read -> next cycle state IDLE, strobes 1, read_data=0; the following read completes normally.
- With SRAM_POSTED_WRITE_EN: write at 1032 -> ready=1 in the same cycle. A read issued the next cycle stalls until the write's HI phase ends, then takes its full 5-cycle latency.
